// File: rtl/fir_xifu_pkg.sv
// rtl/fir_xifu_pkg.sv - shared types and constants for the FIR XIFU pipeline stages
package fir_xifu_pkg;

    localparam int unsigned FIR_XIFU_ID_WIDTH = 4;
    localparam int unsigned FIR_XIFU_XREG_AW  = 5;

    typedef enum logic [1:0] {
        INSTR_NONE     = 2'd0,
        INSTR_XFIRDOTP = 2'd1,
        INSTR_XFIRLW   = 2'd2,
        INSTR_XFIRSW   = 2'd3
    } fir_xifu_instr_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        RES_WAIT = 2'd2
    } fir_xifu_wb_state_e;

    typedef struct packed {
        logic [31:0]                   result;
        logic [4:0]                    rs1;
        logic [4:0]                    rs2;
        logic [FIR_XIFU_XREG_AW-1:0]   rd;
        fir_xifu_instr_e               instr;
        logic [FIR_XIFU_ID_WIDTH-1:0]  id;
    } fir_xifu_ex2wb_t;

    typedef struct packed {
        logic                          we;
        logic [FIR_XIFU_XREG_AW-1:0]   addr;
        logic [31:0]                   data;
    } fir_xifu_wb2regfile_t;

    typedef struct packed {
        logic [FIR_XIFU_ID_WIDTH-1:0]  id;
        logic [31:0]                   data;
        logic [4:0]                    rd;
        logic                          we;
    } fir_xifu_result_t;

endpackage

// File: rtl/fir_xifu_wb_skid.sv
// rtl/fir_xifu_wb_skid.sv - one-entry registered stage on the X-interface result channel
module fir_xifu_wb_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic [W-1:0] s_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] m_tdata
);

    logic         full_q;
    logic [W-1:0] data_q;

    // Accept only when empty so the upstream ready never sees m_tready combinationally.
    assign s_tready = !full_q;
    assign m_tvalid = full_q;
    assign m_tdata  = data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (s_tvalid && s_tready) begin
            full_q <= 1'b1;
            data_q <= s_tdata;
        end else if (m_tready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/fir_xifu_wb.sv
// rtl/fir_xifu_wb.sv - FIR XIFU writeback stage; FIR_XIFU_WB_RESULT_SKID_EN adds a result output register
module fir_xifu_wb
    import fir_xifu_pkg::*;
#(
    parameter int unsigned ID_WIDTH = FIR_XIFU_ID_WIDTH,
    parameter int unsigned XREG_AW  = FIR_XIFU_XREG_AW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  fir_xifu_ex2wb_t      ex2wb_i,
    output logic                 ready_o,
    input  logic                 mem_result_valid_i,
    input  logic [ID_WIDTH-1:0]  mem_result_id_i,
    input  logic [31:0]          mem_result_rdata_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [ID_WIDTH-1:0]  result_id_o,
    output logic [31:0]          result_data_o,
    output logic [4:0]           result_rd_o,
    output logic                 result_we_o,
    output logic                 wb2regfile_we_o,
    output logic [XREG_AW-1:0]   wb2regfile_addr_o,
    output logic [31:0]          wb2regfile_data_o
);

    fir_xifu_wb_state_e   state_q, state_d;
    logic [31:0]          ldata_q;
    logic                 instr_valid;
    logic                 is_lw;
    logic                 is_dotp;
    logic                 mem_match;
    logic                 data_avail;
    logic [31:0]          load_data;
    logic                 res_valid;
    logic                 res_ready;
    logic                 commit;
    fir_xifu_result_t     res_payload;
    fir_xifu_wb2regfile_t rf;
    logic                 unused_rs2;

    assign unused_rs2  = ^ex2wb_i.rs2;

    assign instr_valid = ex2wb_i.instr != INSTR_NONE;
    assign is_lw       = ex2wb_i.instr == INSTR_XFIRLW;
    assign is_dotp     = ex2wb_i.instr == INSTR_XFIRDOTP;

    // Once data sits in ldata_q, later responses with the same id are not ours.
    assign mem_match   = is_lw && (state_q != RES_WAIT) && mem_result_valid_i
                         && (mem_result_id_i == ex2wb_i.id);
    assign data_avail  = (state_q == RES_WAIT) || mem_match;
    assign load_data   = (state_q == RES_WAIT) ? ldata_q : mem_result_rdata_i;
    assign res_valid   = instr_valid && (!is_lw || data_avail);
    assign commit      = res_valid && res_ready;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            ldata_q <= '0;
        end else if (mem_match) begin
            ldata_q <= mem_result_rdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, MEM_WAIT: begin
                if (!is_lw) begin
                    state_d = IDLE;
                end else if (mem_match) begin
                    state_d = commit ? IDLE : RES_WAIT;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            RES_WAIT: begin
                if (commit || !is_lw) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Side effects only in the commit cycle, so a stalled instruction writes exactly once.
    always_comb begin
        res_payload = '0;
        rf          = '0;
        if (res_valid) begin
            res_payload.id = ex2wb_i.id;
            if (!is_dotp) begin
                res_payload.data = ex2wb_i.result;
                res_payload.rd   = ex2wb_i.rs1;
                res_payload.we   = 1'b1;
            end
        end
        if (commit && !clear_i && (is_dotp || is_lw)) begin
            rf.we   = 1'b1;
            rf.addr = ex2wb_i.rd;
            rf.data = is_dotp ? ex2wb_i.result : load_data;
        end
        ready_o = !instr_valid || commit;
    end

    assign wb2regfile_we_o   = rf.we;
    assign wb2regfile_addr_o = rf.addr;
    assign wb2regfile_data_o = rf.data;

`ifdef FIR_XIFU_WB_RESULT_SKID_EN
    fir_xifu_result_t skid_data;
    logic             skid_valid;

    fir_xifu_wb_skid #(
        .W($bits(fir_xifu_result_t))
    ) u_skid (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (clear_i),
        .s_tvalid (res_valid),
        .s_tready (res_ready),
        .s_tdata  (res_payload),
        .m_tvalid (skid_valid),
        .m_tready (result_ready_i),
        .m_tdata  (skid_data)
    );

    assign result_valid_o = skid_valid;
    assign result_id_o    = skid_data.id;
    assign result_data_o  = skid_data.data;
    assign result_rd_o    = skid_data.rd;
    assign result_we_o    = skid_data.we;
`else
    assign res_ready      = result_ready_i;
    assign result_valid_o = res_valid;
    assign result_id_o    = res_payload.id;
    assign result_data_o  = res_payload.data;
    assign result_rd_o    = res_payload.rd;
    assign result_we_o    = res_payload.we;
`endif

endmodule

// File: tb/tb_fir_xifu_wb.sv
// tb/tb_fir_xifu_wb.sv - randomized self-checking bench for the FIR XIFU writeback stage
module tb_fir_xifu_wb;
    import fir_xifu_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            clear_i;
    fir_xifu_ex2wb_t ex2wb;
    logic            ready_o;
    logic            mem_result_valid_i;
    logic [3:0]      mem_result_id_i;
    logic [31:0]     mem_result_rdata_i;
    logic            result_valid_o;
    logic            result_ready_i;
    logic [3:0]      result_id_o;
    logic [31:0]     result_data_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o;
    logic            wb2regfile_we_o;
    logic [4:0]      wb2regfile_addr_o;
    logic [31:0]     wb2regfile_data_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_got;
    logic [31:0] m_ldata;

    always #5 clk_i = ~clk_i;

    fir_xifu_wb dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .clear_i            (clear_i),
        .ex2wb_i            (ex2wb),
        .ready_o            (ready_o),
        .mem_result_valid_i (mem_result_valid_i),
        .mem_result_id_i    (mem_result_id_i),
        .mem_result_rdata_i (mem_result_rdata_i),
        .result_valid_o     (result_valid_o),
        .result_ready_i     (result_ready_i),
        .result_id_o        (result_id_o),
        .result_data_o      (result_data_o),
        .result_rd_o        (result_rd_o),
        .result_we_o        (result_we_o),
        .wb2regfile_we_o    (wb2regfile_we_o),
        .wb2regfile_addr_o  (wb2regfile_addr_o),
        .wb2regfile_data_o  (wb2regfile_data_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %08h want %08h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: called at negedge, checks outputs, advances the reference model.
    task automatic step(input logic mv, input logic [3:0] mid, input logic [31:0] md,
                        input logic rr, input logic clr, input logic rs, output logic hs);
        logic        lw_match, ev, e_rfwe, is_dotp, is_lw, is_none;
        logic [31:0] ldv;
        mem_result_valid_i = mv;
        mem_result_id_i    = mid;
        mem_result_rdata_i = md;
        result_ready_i     = rr;
        clear_i            = clr;
        rst_i              = rs;
        #1;
        is_dotp  = ex2wb.instr == INSTR_XFIRDOTP;
        is_lw    = ex2wb.instr == INSTR_XFIRLW;
        is_none  = ex2wb.instr == INSTR_NONE;
        lw_match = is_lw && !m_got && mv && (mid == ex2wb.id);
        ldv      = m_got ? m_ldata : md;
        ev       = !is_none && (!is_lw || m_got || lw_match);
        hs       = ev && rr;
        check("res_valid", 32'(result_valid_o), 32'(ev));
        check("ready", 32'(ready_o), 32'(is_none || hs));
        if (ev) begin
            check("res_id", 32'(result_id_o), 32'(ex2wb.id));
            check("res_we", 32'(result_we_o), 32'(!is_dotp));
            check("res_data", result_data_o, is_dotp ? 32'd0 : ex2wb.result);
            if (!is_dotp) check("res_rd", 32'(result_rd_o), 32'(ex2wb.rs1));
        end else if (is_none) begin
            check("idle_data", result_data_o, 32'd0);
            check("idle_ctl", 32'({result_id_o, result_rd_o, result_we_o}), 32'd0);
        end
        e_rfwe = hs && !clr && (is_dotp || is_lw);
        check("rf_we", 32'(wb2regfile_we_o), 32'(e_rfwe));
        if (e_rfwe) begin
            check("rf_addr", 32'(wb2regfile_addr_o), 32'(ex2wb.rd));
            check("rf_data", wb2regfile_data_o, is_dotp ? ex2wb.result : ldv);
        end else if (is_none) begin
            check("rf_idle", wb2regfile_data_o | 32'(wb2regfile_addr_o), 32'd0);
        end
        @(posedge clk_i);
        if (rs || clr) begin
            m_got   = 1'b0;
            m_ldata = 32'd0;
        end else if (hs) begin
            m_got = 1'b0;
        end else if (lw_match) begin
            m_got   = 1'b1;
            m_ldata = md;
        end
        hs = hs && !rs && !clr;
        @(negedge clk_i);
    endtask

    task automatic issue(input fir_xifu_instr_e k, input logic [31:0] res, input logic [4:0] rs1,
                         input logic [4:0] rd, input logic [3:0] id, input logic [31:0] ld,
                         input int mem_dly, input int bad_at, input int rdy_low, input bit rnd,
                         output int cycles);
        logic        hs, mv, rr;
        logic [3:0]  mid;
        logic [31:0] md;
        ex2wb.result = res;
        ex2wb.rs1    = rs1;
        ex2wb.rs2    = 5'($urandom);
        ex2wb.rd     = rd;
        ex2wb.instr  = k;
        ex2wb.id     = id;
        cycles = 0;
        hs     = 1'b0;
        while (!hs && cycles < 100) begin
            mv  = 1'b0;
            mid = 4'd0;
            md  = $urandom;
            if (k == INSTR_XFIRLW && cycles == mem_dly) begin
                mv = 1'b1; mid = id; md = ld;
            end else if (cycles == bad_at) begin
                mv = 1'b1; mid = id ^ 4'd7;
            end else if (rnd && $urandom_range(0, 3) == 0) begin
                mv  = 1'b1;
                mid = (k == INSTR_XFIRLW && cycles < mem_dly) ? id ^ 4'($urandom_range(1, 15))
                                                              : 4'($urandom);
            end
            rr = rnd ? ($urandom_range(0, 9) < 7) : (cycles >= rdy_low);
            step(mv, mid, md, rr, 1'b0, 1'b0, hs);
            cycles++;
        end
        if (!hs) check("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic            hs;
        int              cyc;
        fir_xifu_instr_e k;
        ex2wb              = '0;
        rst_i              = 1'b1;
        clear_i            = 1'b0;
        mem_result_valid_i = 1'b0;
        mem_result_id_i    = '0;
        mem_result_rdata_i = '0;
        result_ready_i     = 1'b0;
        m_got              = 1'b0;
        m_ldata            = 32'd0;
        @(negedge clk_i);
        step(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b1, hs);
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b1, hs);

        issue(INSTR_XFIRDOTP, 32'h0000_1234, 5'd0, 5'd3, 4'd1, 32'd0, -1, -1, 0, 1'b0, cyc);
        check("dotp_lat", 32'(cyc), 32'd1);
        issue(INSTR_XFIRLW, 32'h0000_1004, 5'd10, 5'd6, 4'd2, 32'hDEAD_BEEF, 3, -1, 0, 1'b0, cyc);
        check("lw_lat", 32'(cyc), 32'd4);
        issue(INSTR_XFIRLW, 32'h0000_2008, 5'd11, 5'd7, 4'd2, 32'hCAFE_F00D, 4, 1, 0, 1'b0, cyc);
        check("lw_badid_lat", 32'(cyc), 32'd5);
        issue(INSTR_XFIRSW, 32'h0000_3000, 5'd12, 5'd1, 4'd3, 32'd0, -1, -1, 4, 1'b0, cyc);
        check("sw_stall_lat", 32'(cyc), 32'd5);

        ex2wb = '{result: 32'h4000, rs1: 5'd9, rs2: 5'd0, rd: 5'd4, instr: INSTR_XFIRLW, id: 4'd1};
        step(1'b1, 4'd1, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, hs);
        step(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, hs);
        step(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, 1'b0, hs);
        ex2wb = '0;
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, hs);
        check("clr_ldata", dut.ldata_q, 32'd0);

        ex2wb = '{result: 32'h5000, rs1: 5'd8, rs2: 5'd0, rd: 5'd2, instr: INSTR_XFIRLW, id: 4'd7};
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, hs);
        step(1'b1, 4'd6, 32'h1111_2222, 1'b1, 1'b0, 1'b0, hs);
        ex2wb = '0;
        step(1'b1, 4'd7, 32'h3333_4444, 1'b1, 1'b0, 1'b1, hs);
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 1'b0, hs);
        for (int i = 0; i < 8; i++) begin
            issue(INSTR_XFIRDOTP, $urandom, 5'($urandom), 5'($urandom), 4'($urandom),
                  32'd0, -1, -1, 0, 1'b0, cyc);
            check("dotp_tput", 32'(cyc), 32'd1);
        end

        for (int i = 0; i < 150; i++) begin
            k = fir_xifu_instr_e'($urandom_range(0, 3));
            if (k == INSTR_NONE) begin
                ex2wb = '0;
                step(1'($urandom), 4'($urandom), $urandom, 1'($urandom), 1'b0, 1'b0, hs);
            end else begin
                issue(k, $urandom, 5'($urandom), 5'($urandom), 4'($urandom), $urandom,
                      $urandom_range(0, 4), -1, 0, 1'b1, cyc);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
